// File: rtl/fnd4_scan_capture.sv
// rtl/fnd4_scan_capture.sv - decodes a scanned 4-digit 7-segment bus back into 16-bit BCD frames
module fnd4_scan_capture #(
  parameter int SETTLE_CYC   = 4,
  parameter int TIMEOUT_CYC  = 2000000,
  parameter int COM_ACT_LOW  = 1,
  parameter int SEG_ACT_HIGH = 1
) (
  input  logic        iCLK,
  input  logic        iRESET,
  input  logic [3:0]  iCOM_FND,
  input  logic [7:0]  iDATA_FND,
  output logic [15:0] oBCD,
  output logic        oVALID,
  output logic        oERR,
  output logic        oSTALE
);

  localparam int CW = $clog2(SETTLE_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;

  state_t         state_q, state_d;
  logic [3:0]     com_r;
  logic [7:0]     seg_r;
  logic [11:0]    cur, pat_q, pat_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           eval;
  logic [3:0]     seen_q, seen_new;
  logic [15:0]    shadow_q, shadow_w;
  logic [TW-1:0]  tcnt_q;
  logic [4:0]     dec;
  logic [1:0]     idx;
  logic           legal;

  // Normalise to active-high; dp is forced to 0 so it never affects comparisons.
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      com_r <= 4'h0;
      seg_r <= 8'h00;
    end else begin
      com_r <= (COM_ACT_LOW != 0) ? ~iCOM_FND : iCOM_FND;
      seg_r <= ((SEG_ACT_HIGH != 0) ? iDATA_FND : ~iDATA_FND) & 8'hFE;
    end
  end

  assign cur = {com_r, seg_r};

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state_q <= IDLE;
      pat_q   <= 12'h000;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    cnt_d   = cnt_q;
    eval    = 1'b0;
    case (state_q)
      IDLE: begin
        if (com_r != 4'h0) begin
          pat_d   = cur;
          cnt_d   = CW'(1);
          state_d = SETTLE;
        end
      end
      SETTLE, HELD: begin
        if (cur != pat_q) begin
          pat_d   = cur;
          cnt_d   = CW'(1);
          state_d = (com_r == 4'h0) ? IDLE : SETTLE;
        end else if (state_q == SETTLE) begin
          if (cnt_q == CW'(SETTLE_CYC)) begin
            eval    = 1'b1;
            state_d = HELD;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Returns {legal, bcd} for an a..g pattern with dp already cleared.
  function automatic logic [4:0] decode(input logic [7:0] s);
    case (s)
      8'hFC:   decode = 5'h10;
      8'h60:   decode = 5'h11;
      8'hDA:   decode = 5'h12;
      8'hF2:   decode = 5'h13;
      8'h66:   decode = 5'h14;
      8'hB6:   decode = 5'h15;
      8'hBE:   decode = 5'h16;
      8'hE0:   decode = 5'h17;
      8'hFE:   decode = 5'h18;
      8'hF6:   decode = 5'h19;
      default: decode = 5'h00;
    endcase
  endfunction

  always_comb begin
    dec   = decode(pat_q[7:0]);
    legal = dec[4] && ($countones(pat_q[11:8]) == 1);
    case (pat_q[11:8])
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    seen_new = seen_q | (4'b0001 << idx);
    shadow_w = shadow_q;
    shadow_w[{idx, 2'b00} +: 4] = dec[3:0];
  end

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      oBCD     <= 16'h0000;
      oVALID   <= 1'b0;
      oERR     <= 1'b0;
      seen_q   <= 4'h0;
      shadow_q <= 16'h0000;
      tcnt_q   <= '0;
    end else begin
      oVALID <= 1'b0;
      oERR   <= 1'b0;
      if (tcnt_q != TW'(TIMEOUT_CYC))
        tcnt_q <= tcnt_q + TW'(1);
      if (eval) begin
        if (!legal) begin
          oERR   <= 1'b1;
          seen_q <= 4'h0;
        end else begin
          shadow_q <= shadow_w;
          if (seen_new == 4'hF) begin
            oBCD   <= shadow_w;
            oVALID <= 1'b1;
            seen_q <= 4'h0;
            tcnt_q <= '0;
          end else begin
            seen_q <= seen_new;
          end
        end
      end
    end
  end

  // A frame clears the counter on the same edge, so oVALID always wins over oSTALE.
  assign oSTALE = (tcnt_q == TW'(TIMEOUT_CYC));

endmodule

// File: tb/tb_fnd4_scan_capture.sv
// tb/tb_fnd4_scan_capture.sv - directed table-driven bench for fnd4_scan_capture
module tb_fnd4_scan_capture;

  localparam int SETTLE = 4;
  localparam int TMO    = 100;

  logic        iCLK = 1'b0;
  logic        iRESET;
  logic [3:0]  iCOM_FND;
  logic [7:0]  iDATA_FND;
  logic [15:0] oBCD;
  logic        oVALID, oERR, oSTALE;

  fnd4_scan_capture #(.SETTLE_CYC(SETTLE), .TIMEOUT_CYC(TMO), .COM_ACT_LOW(1), .SEG_ACT_HIGH(1)) dut (
    .iCLK(iCLK), .iRESET(iRESET), .iCOM_FND(iCOM_FND), .iDATA_FND(iDATA_FND),
    .oBCD(oBCD), .oVALID(oVALID), .oERR(oERR), .oSTALE(oSTALE)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    logic [3:0]  com;
    logic [7:0]  data;
    int          cyc;
    int          exp_v;
    int          exp_e;
    logic [15:0] exp_bcd;
  } vec_t;

  vec_t vecs[$];
  int   passes = 0, total = 0;
  int   vcnt, ecnt, both_total = 0;
  logic stale_at_v, stale_pre_v, prev_stale;

  localparam logic [3:0] U = 4'b1110, T = 4'b1101, H = 4'b1011, K = 4'b0111;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic add(input logic [3:0] c, input logic [7:0] d, input int n,
                     input int v, input int e, input logic [15:0] b);
    vec_t x;
    x.com = c; x.data = d; x.cyc = n; x.exp_v = v; x.exp_e = e; x.exp_bcd = b;
    vecs.push_back(x);
  endtask

  // Drive one bus pattern for n cycles, counting pulses sampled 1ns after each edge.
  task automatic apply(input logic [3:0] c, input logic [7:0] d, input int n);
    iCOM_FND = c; iDATA_FND = d;
    vcnt = 0; ecnt = 0;
    repeat (n) begin
      @(posedge iCLK); #1;
      if (oVALID) begin vcnt++; stale_at_v = oSTALE; stale_pre_v = prev_stale; end
      if (oERR) ecnt++;
      if (oVALID && oERR) both_total++;
      prev_stale = oSTALE;
    end
  endtask

  initial begin
    int k;
    string nm;
    // T1: "1234"
    add(U, 8'h66, 10, 0, 0, 16'h0000);
    add(T, 8'hF2, 10, 0, 0, 16'h0000);
    add(H, 8'hDA, 10, 0, 0, 16'h0000);
    add(K, 8'h60, 10, 1, 0, 16'h1234);
    // T2: 2-cycle 0xFE glitch on each COM change
    add(U, 8'hFE, 2, 0, 0, 16'h1234);  add(U, 8'h66, 10, 0, 0, 16'h1234);
    add(T, 8'hFE, 2, 0, 0, 16'h1234);  add(T, 8'hF2, 10, 0, 0, 16'h1234);
    add(H, 8'hFE, 2, 0, 0, 16'h1234);  add(H, 8'hDA, 10, 0, 0, 16'h1234);
    add(K, 8'hFE, 2, 0, 0, 16'h1234);  add(K, 8'h60, 10, 1, 0, 16'h1234);
    // T3: illegal segment pattern, then "5678"
    add(U, 8'h02, 10, 0, 1, 16'h1234);
    add(U, 8'hFE, 10, 0, 0, 16'h1234);
    add(T, 8'hE0, 10, 0, 0, 16'h1234);
    add(H, 8'hBE, 10, 0, 0, 16'h1234);
    add(K, 8'hB6, 10, 1, 0, 16'h5678);
    // T4: multi-COM error clears seen; dp set on some digits; then "9999"
    add(U, 8'hF6, 10, 0, 0, 16'h5678);
    add(T, 8'hF7, 10, 0, 0, 16'h5678);
    add(4'b1100, 8'h66, 10, 0, 1, 16'h5678);
    add(H, 8'hF6, 10, 0, 0, 16'h5678);
    add(K, 8'hF7, 10, 0, 0, 16'h5678);
    add(U, 8'hF6, 10, 0, 0, 16'h5678);
    add(T, 8'hF6, 10, 1, 0, 16'h9999);
    add(4'b1111, 8'h00, 6, 0, 0, 16'h9999);

    iRESET = 1'b1; iCOM_FND = U; iDATA_FND = 8'h66; prev_stale = 1'b0;
    repeat (3) @(posedge iCLK);
    #1;
    check("reset_bcd", 32'(oBCD), 32'h0);
    check("reset_valid", 32'(oVALID), 32'h0);
    check("reset_err", 32'(oERR), 32'h0);
    check("reset_stale", 32'(oSTALE), 32'h0);
    iRESET = 1'b0; iCOM_FND = 4'b1111; iDATA_FND = 8'h00;
    @(posedge iCLK); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].com, vecs[i].data, vecs[i].cyc);
      nm = $sformatf("vec%0d", i);
      check({nm, "_valid"}, 32'(vcnt), 32'(vecs[i].exp_v));
      check({nm, "_err"}, 32'(ecnt), 32'(vecs[i].exp_e));
      check({nm, "_bcd"}, 32'(oBCD), 32'(vecs[i].exp_bcd));
    end

    // Latency: pins change just after edge E0, sampled at edge N=E0+1, visible after N+SETTLE+1.
    apply(U, 8'h66, 10); apply(T, 8'hF2, 10); apply(H, 8'hDA, 10);
    check("lat_pre_valid", 32'(vcnt), 32'h0);
    iCOM_FND = K; iDATA_FND = 8'h60;
    k = 0;
    for (int e = 1; e <= 20 && k == 0; e++) begin
      @(posedge iCLK); #1;
      if (oVALID) k = e;
    end
    check("lat_edges", 32'(k), 32'(SETTLE + 2));
    check("lat_bcd", 32'(oBCD), 32'h1234);
    check("lat_stale_at_valid", 32'(oSTALE), 32'h0);
    @(posedge iCLK); #1;
    check("lat_pulse_width", 32'(oVALID), 32'h0);

    // T5: timeout; one edge already elapsed since the frame
    repeat (TMO - 2) @(posedge iCLK);
    #1;
    check("stale_before", 32'(oSTALE), 32'h0);
    @(posedge iCLK); #1;
    check("stale_at_tmo", 32'(oSTALE), 32'h1);
    prev_stale = oSTALE;
    apply(U, 8'h60, 10); apply(T, 8'hDA, 10); apply(H, 8'hF2, 10);
    check("stale_held", 32'(oSTALE), 32'h1);
    apply(K, 8'h66, 10);
    check("t5_valid", 32'(vcnt), 32'h1);
    check("t5_bcd", 32'(oBCD), 32'h4321);
    check("t5_stale_at_valid", 32'(stale_at_v), 32'h0);
    check("t5_stale_before_valid", 32'(stale_pre_v), 32'h1);

    // T6: reset after 3 accepted digits of "0420"
    apply(U, 8'hFC, 10); apply(T, 8'hDA, 10); apply(H, 8'h66, 10);
    check("t6_pre_valid", 32'(vcnt), 32'h0);
    iRESET = 1'b1; iCOM_FND = 4'b1111; iDATA_FND = 8'h00;
    repeat (2) @(posedge iCLK);
    #1;
    check("t6_rst_bcd", 32'(oBCD), 32'h0);
    check("t6_rst_valid", 32'(oVALID), 32'h0);
    check("t6_rst_err", 32'(oERR), 32'h0);
    check("t6_rst_stale", 32'(oSTALE), 32'h0);
    iRESET = 1'b0;
    apply(K, 8'hFC, 10);
    check("t6_lone_valid", 32'(vcnt), 32'h0);
    check("t6_lone_err", 32'(ecnt), 32'h0);
    // Thousands is already seen, so the frame completes on the hundreds digit.
    apply(U, 8'hFC, 10);
    check("t6_u_valid", 32'(vcnt), 32'h0);
    apply(T, 8'hDA, 10);
    check("t6_t_valid", 32'(vcnt), 32'h0);
    apply(H, 8'h66, 10);
    check("t6_h_valid", 32'(vcnt), 32'h1);
    check("t6_bcd", 32'(oBCD), 32'h0420);

    check("valid_err_overlap", 32'(both_total), 32'h0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
